// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared definitions for the multi-cycle ALU.
//   fs_e     - function-select opcode space (5-bit FS field)
//   state_e  - control FSM states
//   is_muldiv / is_signed_md / is_div - opcode class helpers
package alu_mc_pkg;

  typedef enum logic [4:0] {
    FS_PASS_S = 5'h00,
    FS_PASS_T = 5'h01,
    FS_ADD    = 5'h02,
    FS_ADDU   = 5'h03,
    FS_SUB    = 5'h04,
    FS_SUBU   = 5'h05,
    FS_SLT    = 5'h06,
    FS_SLTU   = 5'h07,
    FS_AND    = 5'h08,
    FS_OR     = 5'h09,
    FS_XOR    = 5'h0A,
    FS_NOR    = 5'h0B,
    FS_SLL    = 5'h0C,
    FS_SRL    = 5'h0D,
    FS_SRA    = 5'h0E,
    FS_MULU   = 5'h1C,
    FS_DIVU   = 5'h1D,
    FS_MUL    = 5'h1E,
    FS_DIV    = 5'h1F
  } fs_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic is_muldiv(input logic [4:0] fs);
    return (fs == FS_MULU) || (fs == FS_DIVU) || (fs == FS_MUL) || (fs == FS_DIV);
  endfunction

  function automatic logic is_signed_md(input logic [4:0] fs);
    return (fs == FS_MUL) || (fs == FS_DIV);
  endfunction

  function automatic logic is_div(input logic [4:0] fs);
    return (fs == FS_DIVU) || (fs == FS_DIV);
  endfunction

endpackage

// File: rtl/alu_mc_muldiv_iter.sv
// muldiv_iter: shared iterative datapath, shift-add multiply / restoring divide.
//   clk, reset : clock, synchronous active-high reset
//   load_i     : latch operand magnitudes and signs, start W steps
//   div_i      : 1 = divide, 0 = multiply
//   sgn_i      : signed operation
//   a_i, b_i   : operands (multiplicand/dividend, multiplier/divisor)
//   last_o     : high during the final iteration step
//   hi_o, lo_o : sign-corrected product {hi,lo} or remainder/quotient
module muldiv_iter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         div_i,
  input  logic         sgn_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         last_o,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);
  localparam int unsigned CW = $clog2(W);

  logic [W-1:0]   hi_q, lo_q, b_q;
  logic [CW-1:0]  cnt_q;
  logic           run_q, div_q, pneg_q, rneg_q;

  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     mul_sum, div_shift, div_trial;
  logic [2*W-1:0] prod;

  always_comb begin
    a_mag     = (sgn_i && a_i[W-1]) ? -a_i : a_i;
    b_mag     = (sgn_i && b_i[W-1]) ? -b_i : b_i;
    mul_sum   = {1'b0, hi_q} + ({1'b0, b_q} & {(W+1){lo_q[0]}});
    div_shift = {hi_q, lo_q[W-1]};
    // Remainder stays below the divisor, so the trial result always fits W bits.
    div_trial = div_shift - {1'b0, b_q};
    prod      = {hi_q, lo_q};
    if (pneg_q) prod = -prod;
    if (div_q) begin
      lo_o = pneg_q ? -lo_q : lo_q;
      hi_o = rneg_q ? -hi_q : hi_q;
    end else begin
      hi_o = prod[2*W-1:W];
      lo_o = prod[W-1:0];
    end
  end

  assign last_o = run_q && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      div_q  <= 1'b0;
      pneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (load_i) begin
      hi_q   <= '0;
      lo_q   <= a_mag;
      b_q    <= b_mag;
      cnt_q  <= CW'(W - 1);
      run_q  <= 1'b1;
      div_q  <= div_i;
      pneg_q <= sgn_i & (a_i[W-1] ^ b_i[W-1]);
      rneg_q <= sgn_i & a_i[W-1];
    end else if (run_q) begin
      if (div_q) begin
        hi_q <= div_trial[W] ? div_shift[W-1:0] : div_trial[W-1:0];
        lo_q <= {lo_q[W-2:0], ~div_trial[W]};
      end else begin
        hi_q <= mul_sum[W:1];
        lo_q <= {mul_sum[0], lo_q[W-1:1]};
      end
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == '0) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU.
//   clk, reset    : clock, synchronous active-high reset
//   start         : op request, accepted only while busy=0
//   FS            : function select (alu_mc_pkg::fs_e)
//   S, T, shamt   : operands; shifts act on T by shamt
//   busy          : MUL/DIV in progress
//   done          : one-cycle pulse, results valid
//   Y_hi, Y_lo    : upper/remainder, lower/quotient result
//   C, V, N, Z, dz: status flags, dz = divide by zero
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter  int unsigned W   = 32,
  localparam int unsigned SHW = $clog2(W)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [4:0]     FS,
  input  logic [W-1:0]   S,
  input  logic [W-1:0]   T,
  input  logic [SHW-1:0] shamt,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   Y_hi,
  output logic [W-1:0]   Y_lo,
  output logic           C,
  output logic           V,
  output logic           N,
  output logic           Z,
  output logic           dz
);
  state_e       state_q;
  logic [4:0]   fs_q;
  logic [W-1:0] s_q, t_q, yhi_q, ylo_q;
  logic         busy_q, done_q, c_q, v_q, n_q, z_q, dz_q;

  logic         md_load, md_last;
  logic [W-1:0] md_hi, md_lo;

  logic [W:0]   add_r, sub_r, shl_r, shr_r, sra_r;
  logic [W-1:0] alu_lo;
  logic         alu_c, alu_v, alu_n, alu_z, alu_known;

  logic [W-1:0] fix_hi, fix_lo;
  logic         fix_v, fix_n, fix_z, fix_dz;

  assign md_load = (state_q == IDLE) && start && is_muldiv(FS);

  muldiv_iter #(.W(W)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .load_i (md_load),
    .div_i  (is_div(FS)),
    .sgn_i  (is_signed_md(FS)),
    .a_i    (S),
    .b_i    (T),
    .last_o (md_last),
    .hi_o   (md_hi),
    .lo_o   (md_lo)
  );

  // Single-cycle ALU and shifter; shift carries come from one extra guard bit.
  always_comb begin
    add_r     = {1'b0, S} + {1'b0, T};
    sub_r     = {1'b0, S} + {1'b0, ~T} + (W+1)'(1);
    shl_r     = {1'b0, T} << shamt;
    shr_r     = {T, 1'b0} >> shamt;
    sra_r     = $signed({T, 1'b0}) >>> shamt;
    alu_lo    = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_known = 1'b1;
    case (fs_e'(FS))
      FS_PASS_S: alu_lo = S;
      FS_PASS_T: alu_lo = T;
      FS_ADD: begin
        {alu_c, alu_lo} = add_r;
        alu_v = (S[W-1] == T[W-1]) && (add_r[W-1] != S[W-1]);
      end
      FS_ADDU:   {alu_c, alu_lo} = add_r;
      FS_SUB: begin
        {alu_c, alu_lo} = sub_r;
        alu_v = (S[W-1] != T[W-1]) && (sub_r[W-1] != S[W-1]);
      end
      FS_SUBU:   {alu_c, alu_lo} = sub_r;
      FS_SLT:    alu_lo = {{(W-1){1'b0}}, ($signed(S) < $signed(T))};
      FS_SLTU:   alu_lo = {{(W-1){1'b0}}, (S < T)};
      FS_AND:    alu_lo = S & T;
      FS_OR:     alu_lo = S | T;
      FS_XOR:    alu_lo = S ^ T;
      FS_NOR:    alu_lo = ~(S | T);
      FS_SLL:    {alu_c, alu_lo} = shl_r;
      FS_SRL:    {alu_lo, alu_c} = shr_r;
      FS_SRA:    {alu_lo, alu_c} = sra_r;
      default:   alu_known = 1'b0;
    endcase
    alu_z = alu_known && (alu_lo == '0);
    alu_n = alu_known && alu_lo[W-1] && (FS != FS_ADDU) && (FS != FS_SUBU);
  end

  // Final MUL/DIV result selection, including divide-by-zero and MIN/-1 cases.
  always_comb begin
    fix_hi = md_hi;
    fix_lo = md_lo;
    fix_v  = 1'b0;
    fix_dz = 1'b0;
    if (is_div(fs_q)) begin
      if (t_q == '0) begin
        fix_hi = s_q;
        fix_lo = '1;
        fix_v  = 1'b1;
        fix_dz = 1'b1;
      end else begin
        fix_v = (fs_q == FS_DIV) && (s_q == {1'b1, {(W-1){1'b0}}}) && (t_q == '1);
      end
      fix_z = (fix_lo == '0);
      fix_n = fix_lo[W-1];
    end else begin
      fix_z = ({fix_hi, fix_lo} == '0);
      fix_n = fix_hi[W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fs_q    <= '0;
      s_q     <= '0;
      t_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      yhi_q   <= '0;
      ylo_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (is_muldiv(FS)) begin
              fs_q    <= FS;
              s_q     <= S;
              t_q     <= T;
              busy_q  <= 1'b1;
              state_q <= ITER;
            end else begin
              yhi_q  <= '0;
              ylo_q  <= alu_lo;
              c_q    <= alu_c;
              v_q    <= alu_v;
              n_q    <= alu_n;
              z_q    <= alu_z;
              dz_q   <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        ITER: if (md_last) state_q <= FIX;
        FIX: begin
          yhi_q   <= fix_hi;
          ylo_q   <= fix_lo;
          c_q     <= 1'b0;
          v_q     <= fix_v;
          n_q     <= fix_n;
          z_q     <= fix_z;
          dz_q    <= fix_dz;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Y_hi = yhi_q;
  assign Y_lo = ylo_q;
  assign C    = c_q;
  assign V    = v_q;
  assign N    = n_q;
  assign Z    = z_q;
  assign dz   = dz_q;

endmodule
